// File: rtl/pll_sequencer.sv
// pll_sequencer: power-up, lock supervision and recovery controller for the
// fabric PLL. It sequences PLL power-down and output-divider reset, then holds
// the system reset until lock has been continuously stable. On lock timeout or
// loss of lock it power-cycles the PLL, with bounded retries and a sticky
// fault state.
module pll_sequencer #(
    parameter int PD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int DIVRST_CYCLES = 4,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       pll_lock,
    output logic       pll_powerdown_n,
    output logic       pll_oadivrst,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fault,
    output logic [3:0] retries,
    output logic [7:0] lock_losses
);

    typedef enum logic [2:0] {
        ST_PD        = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_DIVRST    = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Terminal counter values, one per timed state.
    localparam logic [CNT_WIDTH-1:0] PD_LAST     = CNT_WIDTH'(PD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] DIVRST_LAST = CNT_WIDTH'(DIVRST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_LIMIT = 4'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]             retries_q, retries_d;
    logic [7:0]             lock_losses_q, lock_losses_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   powerdown_n_q, powerdown_n_d;
    logic                   oadivrst_q, oadivrst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   locked_q, locked_d;
    logic                   fault_q, fault_d;
    logic                   lock_s;

    // pll_lock is asynchronous to clk; only the second synchronizer stage is used.
    assign lock_s = sync2_q;

    // Synchronizer shift: pll_lock -> sync1 -> sync2.
    always_comb begin
        sync1_d = pll_lock;
        sync2_d = sync1_q;
    end

    // Next-state, retry and lock-loss bookkeeping; restart overrides everything.
    always_comb begin
        state_d       = state_q;
        retries_d     = retries_q;
        lock_losses_d = lock_losses_q;
        if (restart) begin
            state_d   = ST_PD;
            retries_d = 4'd0;
        end else begin
            case (state_q)
                ST_PD: begin
                    if (cnt_q == PD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_PD;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_DIVRST;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retries_q == RETRY_LIMIT) begin
                            state_d = ST_FAULT;
                        end else begin
                            state_d   = ST_PD;
                            retries_d = retries_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_DIVRST: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == DIVRST_LAST) begin
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DIVRST;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d   = ST_RUN;
                        retries_d = 4'd0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PD;
                        if (lock_losses_q != 8'hFF) begin
                            lock_losses_d = lock_losses_q + 8'd1;
                        end else begin
                            lock_losses_d = lock_losses_q;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_PD;
                end
            endcase
        end
    end

    // State counter: cleared on any state change or restart, frozen in the untimed states.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_RUN) || (state_q == ST_FAULT)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Output decode from the next state so outputs switch on the same edge as the state.
    always_comb begin
        powerdown_n_d = 1'b1;
        oadivrst_d    = 1'b1;
        sys_rst_n_d   = 1'b0;
        locked_d      = 1'b0;
        fault_d       = 1'b0;
        case (state_d)
            ST_PD: begin
                powerdown_n_d = 1'b0;
            end
            ST_WAIT_LOCK: begin
                oadivrst_d = 1'b1;
            end
            ST_DIVRST: begin
                oadivrst_d = 1'b1;
            end
            ST_SETTLE: begin
                oadivrst_d = 1'b0;
            end
            ST_RUN: begin
                oadivrst_d  = 1'b0;
                sys_rst_n_d = 1'b1;
                locked_d    = 1'b1;
            end
            ST_FAULT: begin
                powerdown_n_d = 1'b0;
                fault_d       = 1'b1;
            end
            default: begin
                powerdown_n_d = 1'b0;
            end
        endcase
    end

    // All state and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_PD;
            cnt_q         <= '0;
            retries_q     <= 4'd0;
            lock_losses_q <= 8'd0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            powerdown_n_q <= 1'b0;
            oadivrst_q    <= 1'b1;
            sys_rst_n_q   <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            lock_losses_q <= lock_losses_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            powerdown_n_q <= powerdown_n_d;
            oadivrst_q    <= oadivrst_d;
            sys_rst_n_q   <= sys_rst_n_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_powerdown_n = powerdown_n_q;
    assign pll_oadivrst    = oadivrst_q;
    assign sys_rst_n       = sys_rst_n_q;
    assign locked          = locked_q;
    assign fault           = fault_q;
    assign retries         = retries_q;
    assign lock_losses     = lock_losses_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Testbench for pll_sequencer: directed scenarios with hand-computed cycle
// expectations plus randomized lock/restart/reset traffic, all checked every
// cycle against a deadline-based behavioural model.
module tb_pll_sequencer;

    localparam int PD  = 4;
    localparam int TO  = 32;
    localparam int DR  = 2;
    localparam int ST  = 8;
    localparam int MR  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       restart = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_powerdown_n, pll_oadivrst, sys_rst_n, locked, fault;
    logic [3:0] retries;
    logic [7:0] lock_losses;

    int n_checks = 0;
    int n_pass   = 0;

    pll_sequencer #(
        .PD_CYCLES(PD), .LOCK_TIMEOUT(TO), .DIVRST_CYCLES(DR),
        .STABLE_CYCLES(ST), .MAX_RETRIES(MR), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart), .pll_lock(pll_lock),
        .pll_powerdown_n(pll_powerdown_n), .pll_oadivrst(pll_oadivrst),
        .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault),
        .retries(retries), .lock_losses(lock_losses)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each phase is entered at an edge with an absolute deadline edge; the
    // decision input is the pll_lock value sampled two edges earlier.
    localparam int P_PD = 0, P_WAIT = 1, P_DIV = 2, P_SET = 3, P_RUN = 4, P_FAULT = 5;
    int   m_phase = P_PD;
    int   m_deadline = 0;
    int   m_cyc = 0;
    int   m_retries = 0;
    int   m_losses = 0;
    bit   m_valid = 1'b0;
    logic hist[$];

    function automatic int phase_len(input int p);
        case (p)
            P_PD:    return PD;
            P_WAIT:  return TO;
            P_DIV:   return DR;
            P_SET:   return ST;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input int p);
        m_phase    = p;
        m_deadline = m_cyc + phase_len(p);
    endtask

    // Model update on every active edge, using the inputs the DUT samples.
    always @(posedge clk) begin
        logic ls;
        m_cyc++;
        if (!reset_n) begin
            enter(P_PD);
            m_retries = 0;
            m_losses  = 0;
            hist      = {1'b0, 1'b0};
            m_valid   = 1'b1;
        end else if (m_valid) begin
            ls = hist[hist.size()-2];
            hist.push_back(pll_lock);
            if (hist.size() > 3) void'(hist.pop_front());
            if (restart) begin
                enter(P_PD);
                m_retries = 0;
            end else begin
                case (m_phase)
                    P_PD:   if (m_cyc == m_deadline) enter(P_WAIT);
                    P_WAIT: begin
                        if (ls) enter(P_DIV);
                        else if (m_cyc == m_deadline) begin
                            if (m_retries == MR) enter(P_FAULT);
                            else begin m_retries++; enter(P_PD); end
                        end
                    end
                    P_DIV: begin
                        if (!ls) enter(P_WAIT);
                        else if (m_cyc == m_deadline) enter(P_SET);
                    end
                    P_SET: begin
                        if (!ls) enter(P_WAIT);
                        else if (m_cyc == m_deadline) begin enter(P_RUN); m_retries = 0; end
                    end
                    P_RUN: begin
                        if (!ls) begin
                            enter(P_PD);
                            if (m_losses < 255) m_losses++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("powerdown_n", int'(pll_powerdown_n), int'(!(m_phase == P_PD || m_phase == P_FAULT)));
            check("oadivrst", int'(pll_oadivrst), int'(m_phase != P_SET && m_phase != P_RUN));
            check("sys_rst_n", int'(sys_rst_n), int'(m_phase == P_RUN));
            check("locked", int'(locked), int'(m_phase == P_RUN));
            check("fault", int'(fault), int'(m_phase == P_FAULT));
            check("retries", int'(retries), m_retries);
            check("lock_losses", int'(lock_losses), m_losses);
        end
    end

    // Hold reset for a few cycles with the given lock level, release on a falling edge.
    task automatic do_reset(input logic lvl);
        @(negedge clk);
        reset_n  = 1'b0;
        pll_lock = lvl;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic lvl;

        // Nominal bring-up: RUN exactly 15 edges after release, oadivrst falls at 7.
        do_reset(1'b1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 6)  check("nom_oadivrst_k6", int'(pll_oadivrst), 1);
            if (k == 7)  check("nom_oadivrst_k7", int'(pll_oadivrst), 0);
            if (k == 14) check("nom_sysrst_k14", int'(sys_rst_n), 0);
            if (k == 15) begin
                check("nom_sysrst_k15", int'(sys_rst_n), 1);
                check("nom_locked_k15", int'(locked), 1);
                check("nom_retries", int'(retries), 0);
            end
        end

        // Settle glitch: one low sample during SETTLE reruns DIVRST+SETTLE.
        do_reset(1'b1);
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 9) begin
                check("gl_oadivrst_k9", int'(pll_oadivrst), 0);
                pll_lock = 1'b0;
            end
            if (k == 10) pll_lock = 1'b1;
            if (k == 12) check("gl_oadivrst_k12", int'(pll_oadivrst), 1);
            if (k == 22) check("gl_sysrst_k22", int'(sys_rst_n), 0);
            if (k == 23) begin
                check("gl_locked_k23", int'(locked), 1);
                check("gl_retries", int'(retries), 0);
            end
        end

        // No lock: two retries then FAULT at edge 108, held for 500 cycles.
        do_reset(1'b0);
        for (int k = 1; k <= 108; k++) begin
            @(negedge clk);
            if (k == 36)  check("nl_retries_k36", int'(retries), 1);
            if (k == 72)  check("nl_retries_k72", int'(retries), 2);
            if (k == 107) check("nl_fault_k107", int'(fault), 0);
            if (k == 108) check("nl_fault_k108", int'(fault), 1);
        end
        repeat (500) @(negedge clk);
        check("nl_fault_held", int'(fault), 1);
        check("nl_pdn_held", int'(pll_powerdown_n), 0);

        // Restart out of FAULT with lock present: RUN 15 edges later.
        pll_lock = 1'b1;
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_fault_clear", int'(fault), 0);
        check("rs_retries", int'(retries), 0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14) check("rs_locked_k14", int'(locked), 0);
            if (k == 15) check("rs_locked_k15", int'(locked), 1);
        end

        // Repeated loss of lock in RUN; lock_losses saturates at 255.
        for (int i = 0; i < 300; i++) begin
            pll_lock = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                if (k == 2) check("ll_sysrst_k2", int'(sys_rst_n), 1);
                if (k == 3) check("ll_sysrst_k3", int'(sys_rst_n), 0);
            end
            pll_lock = 1'b1;
            for (int k = 4; k <= 7; k++) begin
                @(negedge clk);
                if (k == 6) check("ll_pdn_k6", int'(pll_powerdown_n), 0);
                if (k == 7) check("ll_pdn_k7", int'(pll_powerdown_n), 1);
            end
            for (int w = 0; w < 40 && !locked; w++) @(negedge clk);
            check("ll_relock", int'(locked), 1);
        end
        check("ll_losses_sat", int'(lock_losses), 255);

        // One-cycle reset pulse in RUN: reset values next edge, then nominal again.
        reset_n = 1'b0;
        @(negedge clk);
        check("rp_pdn", int'(pll_powerdown_n), 0);
        check("rp_oadivrst", int'(pll_oadivrst), 1);
        check("rp_sysrst", int'(sys_rst_n), 0);
        check("rp_losses", int'(lock_losses), 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 14) check("rp_locked_k14", int'(locked), 0);
            if (k == 15) check("rp_locked_k15", int'(locked), 1);
        end

        // Randomized lock segments with sporadic restart and reset pulses.
        for (int seg = 0; seg < 80; seg++) begin
            len = $urandom_range(1, 50);
            lvl = ($urandom_range(0, 3) != 0);
            pll_lock = lvl;
            for (int i = 0; i < len; i++) begin
                restart = ($urandom_range(0, 99) == 0);
                reset_n = ($urandom_range(0, 299) != 0);
                @(negedge clk);
            end
        end
        restart = 1'b0;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
